// File: rtl/cordic_linear_iter.sv
// Iterative linear-mode CORDIC: rotation computes y0 + x0*z0, vectoring computes z0 + y0/x0.
// One micro-rotation per clock; results stay in the working registers until the next start.
module cordic_linear_iter #(
    parameter int WIDTH = 17,
    parameter int ITER  = 16,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    ovf,
    output logic                    err
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1) << FRAC;
    localparam logic [IW-1:0]    L_LAST = IW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_iter;
    logic                    r_mode;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic                    r_ovf;
    logic                    r_err;
    logic                    r_busy;
    logic                    r_done;

    logic signed [WIDTH-1:0] w_shx;
    logic [WIDTH-1:0]        w_step;
    logic                    w_dir_pos;
    logic [WIDTH:0]          w_y_ext;
    logic [WIDTH:0]          w_z_ext;
    logic                    w_step_ovf;

    // Sums are formed one bit wider so a wrap shows up as disagreeing top bits.
    always_comb begin
        w_shx  = r_x >>> r_iter;
        w_step = L_ONE >> r_iter;
        if (r_mode)
            w_dir_pos = (r_y[WIDTH-1] != r_x[WIDTH-1]);
        else
            w_dir_pos = ~r_z[WIDTH-1];
        if (w_dir_pos) begin
            w_y_ext = {r_y[WIDTH-1], r_y} + {w_shx[WIDTH-1], w_shx};
            w_z_ext = {r_z[WIDTH-1], r_z} - {1'b0, w_step};
        end else begin
            w_y_ext = {r_y[WIDTH-1], r_y} - {w_shx[WIDTH-1], w_shx};
            w_z_ext = {r_z[WIDTH-1], r_z} + {1'b0, w_step};
        end
        w_step_ovf = (w_y_ext[WIDTH] ^ w_y_ext[WIDTH-1]) |
                     (w_z_ext[WIDTH] ^ w_z_ext[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_iter  <= '0;
                        r_mode  <= mode;
                        r_x     <= x_in;
                        r_y     <= y_in;
                        r_z     <= z_in;
                        r_ovf   <= 1'b0;
                        r_err   <= mode && (x_in == '0);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_y   <= signed'(w_y_ext[WIDTH-1:0]);
                    r_z   <= signed'(w_z_ext[WIDTH-1:0]);
                    r_ovf <= r_ovf | w_step_ovf;
                    if (r_iter == L_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_iter  <= '0;
                    end else begin
                        r_iter <= r_iter + IW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign x_out = r_x;
    assign y_out = r_y;
    assign z_out = r_z;
    assign ovf   = r_ovf;
    assign err   = r_err;

endmodule

// File: tb/tb_cordic_linear_iter.sv
// Scoreboard bench for cordic_linear_iter: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every done pulse.
module tb_cordic_linear_iter;

    localparam int W = 17;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                mode;
    logic signed [W-1:0] x_in, y_in, z_in;
    logic                busy, done, ovf, err;
    logic signed [W-1:0] x_out, y_out, z_out;

    cordic_linear_iter #(.WIDTH(W), .ITER(N), .FRAC(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
        bit                  chk_vals;
        bit                  chk_ovf;
        bit                  ovf;
        bit                  err;
        int                  acc;
        string               name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                input logic signed [W-1:0] z, input bit cv, input bit co,
                                input bit o, input bit e, input string name);
        exp_t r;
        r.x = x; r.y = y; r.z = z;
        r.chk_vals = cv; r.chk_ovf = co; r.ovf = o; r.err = e;
        r.acc = 0; r.name = name;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done at edge %0d required no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("txn %s: x=%0d y=%0d z=%0d ovf=%0d err=%0d latency=%0d",
                         mon_e.name, x_out, y_out, z_out, ovf, err, cyc - mon_e.acc);
                check({mon_e.name, "_latency"}, cyc - mon_e.acc, N);
                check({mon_e.name, "_busy"}, busy, 0);
                check({mon_e.name, "_err"}, err, mon_e.err);
                if (mon_e.chk_ovf) check({mon_e.name, "_ovf"}, ovf, mon_e.ovf);
                if (mon_e.chk_vals) begin
                    check({mon_e.name, "_x"}, x_out, mon_e.x);
                    check({mon_e.name, "_y"}, y_out, mon_e.y);
                    check({mon_e.name, "_z"}, z_out, mon_e.z);
                end
            end
        end
    end

    task automatic issue(input bit m, input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                         input logic signed [W-1:0] z, input exp_t e);
        @(negedge clk);
        start = 1'b1; mode = m; x_in = x; y_in = y; z_in = z;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done in 40 cycles required done", name);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_z"}, z_out, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // 0.5 * 0.75 rotation and 0.25 / 0.5 vectoring
        issue(1'b0, 17'sd8192, 17'sd0, 17'sd12288, mk(8192, 6145, -1, 1, 1, 0, 0, "rot"));
        wait_done("rot");
        issue(1'b1, 17'sd8192, 17'sd4096, 17'sd0, mk(8192, -1, 8193, 1, 1, 0, 0, "vec"));
        wait_done("vec");

        // x_in == 0 in vectoring flags err, then clears on the next valid operation
        issue(1'b1, 17'sd0, 17'sd4096, 17'sd0, mk(0, 0, 0, 0, 0, 0, 1, "vec_x0"));
        wait_done("vec_x0");
        issue(1'b1, 17'sd8192, 17'sd4096, 17'sd0, mk(8192, -1, 8193, 1, 1, 0, 0, "vec_after_err"));
        wait_done("vec_after_err");

        // y accumulator wraps past +4.0, then a clean operation clears ovf
        issue(1'b0, 17'sd31130, 17'sd49152, 17'sd24576, mk(0, 0, 0, 0, 1, 1, 0, "rot_ovf"));
        wait_done("rot_ovf");
        issue(1'b0, 17'sd8192, 17'sd0, 17'sd12288, mk(8192, 6145, -1, 1, 1, 0, 0, "rot_after_ovf"));
        wait_done("rot_after_ovf");

        // start during RUN must be ignored
        issue(1'b0, 17'sd8192, 17'sd0, 17'sd12288, mk(8192, 6145, -1, 1, 1, 0, 0, "rot_ignore"));
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b1; x_in = 17'sd100; y_in = 17'sd300; z_in = 17'sd500;
        @(negedge clk);
        start = 1'b0;
        wait_done("rot_ignore");
        @(negedge clk);
        check("hold_done", done, 0);
        check("hold_busy", busy, 0);
        check("hold_y", y_out, 6145);
        check("hold_z", z_out, -1);

        // back-to-back: start held during the DONE cycle
        issue(1'b1, 17'sd8192, 17'sd4096, 17'sd0, mk(8192, -1, 8193, 1, 1, 0, 0, "b2b_first"));
        wait_done("b2b_first");
        start = 1'b1; mode = 1'b0; x_in = 17'sd8192; y_in = 17'sd0; z_in = 17'sd12288;
        sb.push_back('{x: 8192, y: 6145, z: -1, chk_vals: 1, chk_ovf: 1, ovf: 0, err: 0,
                       acc: cyc + 1, name: "b2b_second"});
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done("b2b_second");

        // asynchronous reset mid-RUN at i=7
        issue(1'b0, 17'sd8192, 17'sd0, 17'sd12288, mk(8192, 6145, -1, 1, 1, 0, 0, "rot_abort"));
        repeat (7) @(negedge clk);
        check("mid_y", y_out, 6272);
        check("mid_z", z_out, -256);
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 17'sd8192, 17'sd0, 17'sd12288, mk(8192, 6145, -1, 1, 1, 0, 0, "rot_post_rst"));
        wait_done("rot_post_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
